// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential divider: operand width, counter width and FSM encoding.
package div16_seq_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/div16_seq_if.sv
// Start/done handshake and operand/result bundle between a requester and the divider.
interface div16_seq_if #(
    parameter int unsigned WIDTH = div16_seq_pkg::DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div16_seq_sub_trial.sv
// Combinational trial subtract a - b via a + ~b + 1; the MSB of the result is the borrow.
module sub_trial
    import div16_seq_pkg::*;
#(
    parameter int unsigned W = DIV_WIDTH + 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-2:0] o_diff,
    output logic         o_borrow
);

    logic [W-1:0] w_t;

    // Callers keep a < 2*b, so the W-bit result never wraps and its MSB is a true sign bit.
    assign w_t      = i_a + ~i_b + W'(1);
    assign o_diff   = w_t[W-2:0];
    assign o_borrow = w_t[W-1];

endmodule

// File: rtl/div16_seq.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock, start/done handshake.
module div16_seq
    import div16_seq_pkg::*;
(
    input logic        clk,
    input logic        reset,
    div16_seq_if.slave bus
);

    localparam int unsigned WIDTH = DIV_WIDTH;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_last;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};

    sub_trial #(
        .W(WIDTH + 1)
    ) u_trial (
        .i_a     (w_shift),
        .i_b     ({1'b0, r_divisor}),
        .o_diff  (w_diff),
        .o_borrow(w_borrow)
    );

    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
    assign w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
    assign w_last    = (r_cnt == CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_nxt = (bus.divisor != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result registers load on the edge entering DONE so they are valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            r_divisor <= bus.divisor;
                            r_rem     <= '0;
                            r_quo     <= bus.dividend;
                            r_cnt     <= CNT_W'(WIDTH);
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_quotient  <= w_quo_nxt;
                        r_remainder <= w_rem_nxt;
                        r_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state == StRun);
    assign bus.done        = (r_state == StDone);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule
